// File: rtl/coz_pkg.sv
// Decode/issue shared types: decoded instruction, resolved issue packet,
// dispatcher state and the bit-mask helpers used for hazard checks.
package coz_pkg;

  typedef enum logic [2:0] {ISL_YOK, ISL_TS, ISL_OS, ISL_IMM, ISL_CSR} islenec_turu_t;

  typedef struct packed {
    islenec_turu_t tur;
    logic [31:0]   islenec;
  } islenec_t;

  typedef enum logic [2:0] {HEDEF_YOK, TS_YAZ, OS_YAZ, CSR_YAZ, IMM_YAZ} hedef_turu_t;

  typedef struct packed {
    hedef_turu_t tur;
    logic [11:0] adres;
  } sonuc_hedefi_t;

  typedef struct packed {
    logic       olagan_disi;
    logic [4:0] mcause;
  } olagan_disi_t;

  typedef struct packed {
    islenec_t      islenec1;
    islenec_t      islenec2;
    islenec_t      islenec3;
    logic [4:0]    amb_kontrol;
    logic [2:0]    abib_kontrol;
    logic [3:0]    muib_kontrol;
    logic [2:0]    csr_kontrol;
    logic [3:0]    dallanma_kontrol;
    logic [4:0]    os_kontrol;
    sonuc_hedefi_t sonuc1_hedef;
    sonuc_hedefi_t sonuc2_hedef;
    olagan_disi_t  olagan_disi;
  } coz_sonucu_t;

  localparam coz_sonucu_t BOS_COZ_SONUCU = '0;

  typedef struct packed {
    logic [31:0]   deger1;
    logic [31:0]   deger2;
    logic [31:0]   deger3;
    logic [4:0]    amb_kontrol;
    logic [2:0]    abib_kontrol;
    logic [3:0]    muib_kontrol;
    logic [2:0]    csr_kontrol;
    logic [3:0]    dallanma_kontrol;
    logic [4:0]    os_kontrol;
    sonuc_hedefi_t sonuc1_hedef;
    sonuc_hedefi_t sonuc2_hedef;
    olagan_disi_t  olagan_disi;
  } dagitim_paketi_t;

  localparam dagitim_paketi_t BOS_DAGITIM_PAKETI = '0;

  typedef enum logic {CALIS, HATA} dagitici_durum_t;

  function automatic logic [31:0] kaynak_maskesi(islenec_t i, islenec_turu_t tur);
    logic [31:0] m;
    m = '0;
    if (i.tur == tur) m[i.islenec[4:0]] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] hedef_maskesi(sonuc_hedefi_t h, hedef_turu_t tur);
    logic [31:0] m;
    m = '0;
    if (h.tur == tur) m[h.adres[4:0]] = 1'b1;
    return m;
  endfunction

  // TS operands only exist in slots 1..2; elsewhere a TS tag passes the field through.
  function automatic logic [31:0] islenec_degeri(islenec_t i, logic ts_yuvasi,
                                                 logic [31:0] ts_veri, logic [31:0] os_veri);
    logic [31:0] d;
    case (i.tur)
      ISL_TS:           d = !ts_yuvasi ? i.islenec : ((i.islenec[4:0] == 5'd0) ? '0 : ts_veri);
      ISL_OS:           d = os_veri;
      ISL_IMM, ISL_CSR: d = i.islenec;
      default:          d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/puan_tablosu.sv
// Pending-result scoreboard: one bit per architectural register.
module puan_tablosu
  import coz_pkg::*;
#(
  parameter int unsigned YAZMA_PORT_SAYISI = 2,
  parameter bit          X0_MASKELE        = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              hepsini_temizle,
  input  logic [31:0]                       ayarla_maske,
  input  logic [YAZMA_PORT_SAYISI-1:0]      temizle_gecerli,
  input  logic [YAZMA_PORT_SAYISI-1:0][4:0] temizle_adres,
  output logic [31:0]                       bekleyen
);

  logic [31:0] temizle_maske;
  logic [31:0] sonraki;

  // Set is applied after clear so a same-cycle set wins.
  always_comb begin
    temizle_maske = '0;
    for (int unsigned i = 0; i < YAZMA_PORT_SAYISI; i++) begin
      if (temizle_gecerli[i]) temizle_maske[temizle_adres[i]] = 1'b1;
    end
    sonraki = (bekleyen & ~temizle_maske) | ayarla_maske;
    if (X0_MASKELE) sonraki[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  bekleyen <= '0;
    else if (hepsini_temizle) bekleyen <= '0;
    else                      bekleyen <= sonraki;
  end

endmodule

// File: rtl/yurut_dagitici.sv
// Issue stage: hazard check against registered scoreboards, operand read,
// and a valid/ready output register toward the execution units.
module yurut_dagitici
  import coz_pkg::*;
#(
  parameter int unsigned YAZMA_PORT_SAYISI = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              coz_gecerli_i,
  input  coz_sonucu_t                       coz_sonucu_i,
  output logic                              coz_hazir_o,
  output logic [4:0]                        ts_oku_adres_o [2],
  input  logic [31:0]                       ts_oku_veri_i  [2],
  output logic [4:0]                        os_oku_adres_o [3],
  input  logic [31:0]                       os_oku_veri_i  [3],
  input  logic [YAZMA_PORT_SAYISI-1:0]      ts_yaz_gecerli_i,
  input  logic [YAZMA_PORT_SAYISI-1:0][4:0] ts_yaz_adres_i,
  input  logic [YAZMA_PORT_SAYISI-1:0]      os_yaz_gecerli_i,
  input  logic [YAZMA_PORT_SAYISI-1:0][4:0] os_yaz_adres_i,
  output logic                              yurut_gecerli_o,
  input  logic                              yurut_hazir_i,
  output dagitim_paketi_t                   yurut_paket_o,
  input  logic                              temizle_i
);

  dagitici_durum_t durum, durum_sonraki;
  logic [31:0]     ts_bekleyen, os_bekleyen;
  logic [31:0]     ts_ayarla, os_ayarla;
  logic [31:0]     ts_gerekli, os_gerekli;
  logic [31:0]     ts_hedef, os_hedef;
  logic            olagan_disi, tehlike, yer_var, dagit;
  dagitim_paketi_t paket;

  assign olagan_disi = coz_sonucu_i.olagan_disi.olagan_disi;

  always_comb begin
    ts_oku_adres_o[0] = coz_sonucu_i.islenec1.islenec[4:0];
    ts_oku_adres_o[1] = coz_sonucu_i.islenec2.islenec[4:0];
    os_oku_adres_o[0] = coz_sonucu_i.islenec1.islenec[4:0];
    os_oku_adres_o[1] = coz_sonucu_i.islenec2.islenec[4:0];
    os_oku_adres_o[2] = coz_sonucu_i.islenec3.islenec[4:0];
  end

  // Sources and WAW destinations share one mask per file; x0 never reads as pending.
  always_comb begin
    ts_hedef   = hedef_maskesi(coz_sonucu_i.sonuc1_hedef, TS_YAZ)
               | hedef_maskesi(coz_sonucu_i.sonuc2_hedef, TS_YAZ);
    os_hedef   = hedef_maskesi(coz_sonucu_i.sonuc1_hedef, OS_YAZ)
               | hedef_maskesi(coz_sonucu_i.sonuc2_hedef, OS_YAZ);
    ts_gerekli = kaynak_maskesi(coz_sonucu_i.islenec1, ISL_TS)
               | kaynak_maskesi(coz_sonucu_i.islenec2, ISL_TS) | ts_hedef;
    os_gerekli = kaynak_maskesi(coz_sonucu_i.islenec1, ISL_OS)
               | kaynak_maskesi(coz_sonucu_i.islenec2, ISL_OS)
               | kaynak_maskesi(coz_sonucu_i.islenec3, ISL_OS) | os_hedef;
    tehlike    = (|(ts_gerekli & ts_bekleyen)) || (|(os_gerekli & os_bekleyen));
  end

  assign yer_var     = !yurut_gecerli_o || yurut_hazir_i;
  assign coz_hazir_o = yer_var && (durum == CALIS) && (olagan_disi || !tehlike);
  assign dagit       = coz_gecerli_i && coz_hazir_o && !temizle_i;
  assign ts_ayarla   = (dagit && !olagan_disi) ? ts_hedef : '0;
  assign os_ayarla   = (dagit && !olagan_disi) ? os_hedef : '0;

  always_comb begin
    paket                  = BOS_DAGITIM_PAKETI;
    paket.deger1           = islenec_degeri(coz_sonucu_i.islenec1, 1'b1,
                                            ts_oku_veri_i[0], os_oku_veri_i[0]);
    paket.deger2           = islenec_degeri(coz_sonucu_i.islenec2, 1'b1,
                                            ts_oku_veri_i[1], os_oku_veri_i[1]);
    paket.deger3           = islenec_degeri(coz_sonucu_i.islenec3, 1'b0,
                                            '0, os_oku_veri_i[2]);
    paket.amb_kontrol      = coz_sonucu_i.amb_kontrol;
    paket.abib_kontrol     = coz_sonucu_i.abib_kontrol;
    paket.muib_kontrol     = coz_sonucu_i.muib_kontrol;
    paket.csr_kontrol      = coz_sonucu_i.csr_kontrol;
    paket.dallanma_kontrol = coz_sonucu_i.dallanma_kontrol;
    paket.os_kontrol       = coz_sonucu_i.os_kontrol;
    paket.sonuc1_hedef     = coz_sonucu_i.sonuc1_hedef;
    paket.sonuc2_hedef     = coz_sonucu_i.sonuc2_hedef;
    paket.olagan_disi      = coz_sonucu_i.olagan_disi;
    if (olagan_disi) begin
      paket.deger1 = '0;
      paket.deger2 = '0;
      paket.deger3 = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      yurut_gecerli_o <= 1'b0;
      yurut_paket_o   <= BOS_DAGITIM_PAKETI;
    end else if (temizle_i) begin
      yurut_gecerli_o <= 1'b0;
    end else if (dagit) begin
      yurut_gecerli_o <= 1'b1;
      yurut_paket_o   <= paket;
    end else if (yurut_hazir_i) begin
      yurut_gecerli_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) durum <= CALIS;
    else       durum <= durum_sonraki;
  end

  always_comb begin
    durum_sonraki = durum;
    if (temizle_i)                 durum_sonraki = CALIS;
    else if (dagit && olagan_disi) durum_sonraki = HATA;
  end

  puan_tablosu #(
    .YAZMA_PORT_SAYISI (YAZMA_PORT_SAYISI),
    .X0_MASKELE        (1'b1)
  ) u_ts_puan (
    .clk             (clk_i),
    .rst             (rst_i),
    .hepsini_temizle (temizle_i),
    .ayarla_maske    (ts_ayarla),
    .temizle_gecerli (ts_yaz_gecerli_i),
    .temizle_adres   (ts_yaz_adres_i),
    .bekleyen        (ts_bekleyen)
  );

  puan_tablosu #(
    .YAZMA_PORT_SAYISI (YAZMA_PORT_SAYISI),
    .X0_MASKELE        (1'b0)
  ) u_os_puan (
    .clk             (clk_i),
    .rst             (rst_i),
    .hepsini_temizle (temizle_i),
    .ayarla_maske    (os_ayarla),
    .temizle_gecerli (os_yaz_gecerli_i),
    .temizle_adres   (os_yaz_adres_i),
    .bekleyen        (os_bekleyen)
  );

endmodule

// File: tb/tb_yurut_dagitici.sv
// Self-checking bench for yurut_dagitici: directed scenarios plus random
// traffic against a behavioural issue/scoreboard model.
module tb_yurut_dagitici;
  import coz_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 coz_gecerli_i = 1'b0;
  coz_sonucu_t          coz_sonucu_i = '0;
  logic                 coz_hazir_o;
  logic [4:0]           ts_oku_adres_o [2];
  logic [31:0]          ts_oku_veri_i  [2];
  logic [4:0]           os_oku_adres_o [3];
  logic [31:0]          os_oku_veri_i  [3];
  logic [1:0]           ts_yaz_gecerli_i = '0;
  logic [1:0][4:0]      ts_yaz_adres_i = '0;
  logic [1:0]           os_yaz_gecerli_i = '0;
  logic [1:0][4:0]      os_yaz_adres_i = '0;
  logic                 yurut_gecerli_o;
  logic                 yurut_hazir_i = 1'b0;
  dagitim_paketi_t      yurut_paket_o;
  logic                 temizle_i = 1'b0;

  logic [31:0] ts_rf [32];
  logic [31:0] os_rf [32];

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned wcount = 0;
  int unsigned ocount = 0;

  bit [31:0]       m_ts, m_os;
  bit              m_valid, m_hata;
  dagitim_paketi_t m_pkt;

  always #5 clk = ~clk;

  assign ts_oku_veri_i[0] = ts_rf[ts_oku_adres_o[0]];
  assign ts_oku_veri_i[1] = ts_rf[ts_oku_adres_o[1]];
  assign os_oku_veri_i[0] = os_rf[os_oku_adres_o[0]];
  assign os_oku_veri_i[1] = os_rf[os_oku_adres_o[1]];
  assign os_oku_veri_i[2] = os_rf[os_oku_adres_o[2]];

  yurut_dagitici #(.YAZMA_PORT_SAYISI(2)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .coz_gecerli_i    (coz_gecerli_i),
    .coz_sonucu_i     (coz_sonucu_i),
    .coz_hazir_o      (coz_hazir_o),
    .ts_oku_adres_o   (ts_oku_adres_o),
    .ts_oku_veri_i    (ts_oku_veri_i),
    .os_oku_adres_o   (os_oku_adres_o),
    .os_oku_veri_i    (os_oku_veri_i),
    .ts_yaz_gecerli_i (ts_yaz_gecerli_i),
    .ts_yaz_adres_i   (ts_yaz_adres_i),
    .os_yaz_gecerli_i (os_yaz_gecerli_i),
    .os_yaz_adres_i   (os_yaz_adres_i),
    .yurut_gecerli_o  (yurut_gecerli_o),
    .yurut_hazir_i    (yurut_hazir_i),
    .yurut_paket_o    (yurut_paket_o),
    .temizle_i        (temizle_i)
  );

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  task automatic chk_pkt(input string n, input dagitim_paketi_t got, input dagitim_paketi_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_op(islenec_t i, int slot);
    case (i.tur)
      ISL_TS:           return (slot == 3) ? i.islenec :
                               (i.islenec[4:0] == 5'd0) ? 32'd0 : ts_rf[i.islenec[4:0]];
      ISL_OS:           return os_rf[i.islenec[4:0]];
      ISL_IMM, ISL_CSR: return i.islenec;
      default:          return 32'd0;
    endcase
  endfunction

  function automatic dagitim_paketi_t model_pkt(coz_sonucu_t c);
    dagitim_paketi_t p;
    bit exc = c.olagan_disi.olagan_disi;
    p.deger1           = exc ? 32'd0 : exp_op(c.islenec1, 1);
    p.deger2           = exc ? 32'd0 : exp_op(c.islenec2, 2);
    p.deger3           = exc ? 32'd0 : exp_op(c.islenec3, 3);
    p.amb_kontrol      = c.amb_kontrol;
    p.abib_kontrol     = c.abib_kontrol;
    p.muib_kontrol     = c.muib_kontrol;
    p.csr_kontrol      = c.csr_kontrol;
    p.dallanma_kontrol = c.dallanma_kontrol;
    p.os_kontrol       = c.os_kontrol;
    p.sonuc1_hedef     = c.sonuc1_hedef;
    p.sonuc2_hedef     = c.sonuc2_hedef;
    p.olagan_disi      = c.olagan_disi;
    return p;
  endfunction

  function automatic bit src_busy(islenec_t i, int slot);
    if (i.tur == ISL_TS && slot < 3 && i.islenec[4:0] != 5'd0 && m_ts[i.islenec[4:0]]) return 1'b1;
    if (i.tur == ISL_OS && m_os[i.islenec[4:0]]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit dst_busy(sonuc_hedefi_t d);
    if (d.tur == TS_YAZ && d.adres[4:0] != 5'd0 && m_ts[d.adres[4:0]]) return 1'b1;
    if (d.tur == OS_YAZ && m_os[d.adres[4:0]]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_blocked(coz_sonucu_t c);
    return src_busy(c.islenec1, 1) || src_busy(c.islenec2, 2) || src_busy(c.islenec3, 3)
        || dst_busy(c.sonuc1_hedef) || dst_busy(c.sonuc2_hedef);
  endfunction

  task automatic model_set(input sonuc_hedefi_t d);
    if (d.tur == TS_YAZ && d.adres[4:0] != 5'd0) m_ts[d.adres[4:0]] = 1'b1;
    if (d.tur == OS_YAZ) m_os[d.adres[4:0]] = 1'b1;
  endtask

  task automatic model_reset();
    m_ts = '0; m_os = '0; m_valid = 1'b0; m_hata = 1'b0; m_pkt = BOS_DAGITIM_PAKETI;
  endtask

  // One clock: drive at negedge, check before posedge, advance model across the edge.
  task automatic step(input coz_sonucu_t c, input bit gec, input bit yh, input bit tem,
                      input logic [1:0] tsg, input logic [1:0][4:0] tsa,
                      input logic [1:0] osg, input logic [1:0][4:0] osa, output bit h);
    bit exp_h;
    coz_sonucu_i = c; coz_gecerli_i = gec; yurut_hazir_i = yh; temizle_i = tem;
    ts_yaz_gecerli_i = tsg; ts_yaz_adres_i = tsa;
    os_yaz_gecerli_i = osg; os_yaz_adres_i = osa;
    #1;
    h = coz_hazir_o;
    exp_h = (!m_valid || yh) && !m_hata && (c.olagan_disi.olagan_disi || !model_blocked(c));
    chk("coz_hazir", 32'(coz_hazir_o), 32'(exp_h));
    chk("yurut_gecerli", 32'(yurut_gecerli_o), 32'(m_valid));
    if (m_valid) chk_pkt("yurut_paket", yurut_paket_o, m_pkt);
    if (tem) begin
      m_valid = 1'b0; m_ts = '0; m_os = '0; m_hata = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (tsg[p]) m_ts[tsa[p]] = 1'b0;
        if (osg[p]) m_os[osa[p]] = 1'b0;
      end
      if (gec && exp_h) begin
        m_pkt = model_pkt(c);
        m_valid = 1'b1;
        if (c.olagan_disi.olagan_disi) m_hata = 1'b1;
        else begin
          model_set(c.sonuc1_hedef);
          model_set(c.sonuc2_hedef);
        end
      end else if (yh) m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (tsg[p] && tsa[p] != 5'd0) begin ts_rf[tsa[p]] = 32'hC000_0000 + wcount; wcount++; end
      if (osg[p]) begin os_rf[osa[p]] = 32'hE000_0000 + ocount; ocount++; end
    end
  endtask

  task automatic st(input coz_sonucu_t c, input bit gec, input bit yh, output bit h);
    step(c, gec, yh, 1'b0, '0, '0, '0, '0, h);
  endtask

  function automatic coz_sonucu_t ins(islenec_turu_t t1, logic [31:0] v1,
                                      islenec_turu_t t2, logic [31:0] v2,
                                      islenec_turu_t t3, logic [31:0] v3,
                                      hedef_turu_t d, logic [11:0] a);
    coz_sonucu_t c = '0;
    c.islenec1.tur = t1; c.islenec1.islenec = v1;
    c.islenec2.tur = t2; c.islenec2.islenec = v2;
    c.islenec3.tur = t3; c.islenec3.islenec = v3;
    c.amb_kontrol      = 5'($urandom);
    c.abib_kontrol     = 3'($urandom);
    c.muib_kontrol     = 4'($urandom);
    c.csr_kontrol      = 3'($urandom);
    c.dallanma_kontrol = 4'($urandom);
    c.os_kontrol       = 5'($urandom);
    c.sonuc1_hedef.tur = d; c.sonuc1_hedef.adres = a;
    return c;
  endfunction

  function automatic islenec_t rnd_isl(bit ts_ok);
    islenec_t i;
    i.islenec = $urandom;
    case ($urandom_range(0, 4))
      0:       i.tur = ISL_YOK;
      1:       i.tur = ts_ok ? ISL_TS : ISL_IMM;
      2:       i.tur = ISL_OS;
      3:       i.tur = ISL_IMM;
      default: i.tur = ISL_CSR;
    endcase
    if (i.tur == ISL_TS || i.tur == ISL_OS) i.islenec[4:0] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  function automatic sonuc_hedefi_t rnd_hedef();
    sonuc_hedefi_t d;
    case ($urandom_range(0, 4))
      0:       d.tur = HEDEF_YOK;
      1:       d.tur = TS_YAZ;
      2:       d.tur = OS_YAZ;
      3:       d.tur = CSR_YAZ;
      default: d.tur = IMM_YAZ;
    endcase
    d.adres = (d.tur == TS_YAZ || d.tur == OS_YAZ) ? 12'($urandom_range(0, 7)) : 12'($urandom);
    return d;
  endfunction

  initial begin
    coz_sonucu_t A, B, C, D, E, F, G, X, H, P, Q, R, S, c;
    bit h;
    logic [1:0]      tsg, osg;
    logic [1:0][4:0] tsa, osa;

    for (int i = 0; i < 32; i++) begin
      ts_rf[i] = 32'h1000_0000 + 32'(i);
      os_rf[i] = 32'h2000_0000 + 32'(i);
    end
    ts_rf[0] = 32'hDEAD_0000;
    model_reset();

    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("reset_hazir", 32'(coz_hazir_o), 32'd1);
    chk("reset_gecerli", 32'(yurut_gecerli_o), 32'd0);
    chk_pkt("reset_paket", yurut_paket_o, BOS_DAGITIM_PAKETI);

    // Independent back-to-back issue.
    A = ins(ISL_TS, 32'd2, ISL_IMM, 32'd5, ISL_YOK, 32'd0, TS_YAZ, 12'd1);
    B = ins(ISL_TS, 32'd4, ISL_TS, 32'd5, ISL_YOK, 32'd0, TS_YAZ, 12'd3);
    st(A, 1, 1, h); chk("addi_hazir", 32'(h), 32'd1);
    chk("addi_op1", yurut_paket_o.deger1, 32'h1000_0002);
    chk("addi_op2", yurut_paket_o.deger2, 32'd5);
    st(B, 1, 1, h); chk("add_hazir", 32'(h), 32'd1);
    chk("add_op1", yurut_paket_o.deger1, 32'h1000_0004);
    chk("add_op2", yurut_paket_o.deger2, 32'h1000_0005);

    // RAW on x1 released one cycle after its writeback strobe.
    C = ins(ISL_TS, 32'd1, ISL_TS, 32'd1, ISL_YOK, 32'd0, TS_YAZ, 12'd2);
    st(C, 1, 1, h); chk("raw_stall0", 32'(h), 32'd0);
    st(C, 1, 1, h); chk("raw_stall1", 32'(h), 32'd0);
    step(C, 1, 1, 0, 2'b01, {5'd0, 5'd1}, '0, '0, h); chk("raw_stall_wb", 32'(h), 32'd0);
    st(C, 1, 1, h); chk("raw_release", 32'(h), 32'd1);
    chk("sub_op1", yurut_paket_o.deger1, 32'hC000_0000);
    chk("sub_op2", yurut_paket_o.deger2, 32'hC000_0000);
    D = ins(ISL_TS, 32'd3, ISL_IMM, 32'd0, ISL_YOK, 32'd0, HEDEF_YOK, 12'd0);
    st(D, 0, 1, h); chk("x3_pending", 32'(h), 32'd0);
    step(BOS_COZ_SONUCU, 0, 1, 0, 2'b11, {5'd2, 5'd3}, '0, '0, h);

    // x0 is never hazardous and reads as zero.
    E = ins(ISL_TS, 32'd0, ISL_IMM, 32'd5, ISL_YOK, 32'd0, TS_YAZ, 12'd0);
    F = ins(ISL_TS, 32'd0, ISL_TS, 32'd0, ISL_YOK, 32'd0, TS_YAZ, 12'd6);
    G = ins(ISL_TS, 32'd0, ISL_TS, 32'd0, ISL_YOK, 32'd0, TS_YAZ, 12'd0);
    st(E, 1, 1, h); chk("x0_dst_hazir", 32'(h), 32'd1);
    st(F, 1, 1, h); chk("x0_src_hazir", 32'(h), 32'd1);
    chk("x0_op1", yurut_paket_o.deger1, 32'd0);
    chk("x0_op2", yurut_paket_o.deger2, 32'd0);
    st(G, 0, 1, h); chk("x0_never_set", 32'(h), 32'd1);

    // Exception: bypasses hazards, zero operands, blocks until flush.
    X = ins(ISL_TS, 32'd6, ISL_OS, 32'd3, ISL_IMM, 32'd7, TS_YAZ, 12'd9);
    X.olagan_disi.olagan_disi = 1'b1; X.olagan_disi.mcause = 5'd2;
    st(X, 1, 1, h); chk("exc_hazir", 32'(h), 32'd1);
    chk("exc_op1", yurut_paket_o.deger1, 32'd0);
    chk("exc_op2", yurut_paket_o.deger2, 32'd0);
    chk("exc_op3", yurut_paket_o.deger3, 32'd0);
    chk("exc_mcause", 32'(yurut_paket_o.olagan_disi.mcause), 32'd2);
    st(A, 1, 1, h); chk("hata_hold0", 32'(h), 32'd0);
    st(A, 1, 1, h); chk("hata_hold1", 32'(h), 32'd0);
    step(BOS_COZ_SONUCU, 0, 1, 1, '0, '0, '0, '0, h);
    H = ins(ISL_TS, 32'd6, ISL_TS, 32'd9, ISL_YOK, 32'd0, TS_YAZ, 12'd9);
    st(H, 0, 1, h); chk("flush_cleared", 32'(h), 32'd1);

    // Backpressure holds the packet; same-cycle set/clear leaves x7 pending.
    P = ins(ISL_IMM, 32'd11, ISL_YOK, 32'd0, ISL_YOK, 32'd0, TS_YAZ, 12'd5);
    Q = ins(ISL_IMM, 32'd22, ISL_YOK, 32'd0, ISL_YOK, 32'd0, TS_YAZ, 12'd8);
    st(P, 1, 1, h); chk("p_hazir", 32'(h), 32'd1);
    for (int k = 0; k < 3; k++) begin
      st(Q, 1, 0, h); chk("bp_hazir", 32'(h), 32'd0);
      chk("bp_stable", yurut_paket_o.deger1, 32'd11);
    end
    st(Q, 1, 1, h); chk("bp_release", 32'(h), 32'd1);
    chk("q_op1", yurut_paket_o.deger1, 32'd22);
    R = ins(ISL_IMM, 32'd1, ISL_YOK, 32'd0, ISL_YOK, 32'd0, TS_YAZ, 12'd7);
    S = ins(ISL_TS, 32'd7, ISL_IMM, 32'd0, ISL_YOK, 32'd0, HEDEF_YOK, 12'd0);
    step(R, 1, 1, 0, 2'b01, {5'd0, 5'd7}, '0, '0, h); chk("x7_issue", 32'(h), 32'd1);
    st(S, 1, 0, h); chk("x7_pending", 32'(h), 32'd0);

    // Asynchronous reset mid-stall.
    chk("pre_reset_gecerli", 32'(yurut_gecerli_o), 32'd1);
    #2 rst_i = 1'b1;
    #1 chk("async_reset_gecerli", 32'(yurut_gecerli_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;
    st(S, 0, 1, h); chk("post_reset_hazir", 32'(h), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      c = '0;
      c.islenec1 = rnd_isl(1'b1);
      c.islenec2 = rnd_isl(1'b1);
      c.islenec3 = rnd_isl(1'b0);
      c.amb_kontrol      = 5'($urandom);
      c.abib_kontrol     = 3'($urandom);
      c.muib_kontrol     = 4'($urandom);
      c.csr_kontrol      = 3'($urandom);
      c.dallanma_kontrol = 4'($urandom);
      c.os_kontrol       = 5'($urandom);
      c.sonuc1_hedef = rnd_hedef();
      c.sonuc2_hedef = rnd_hedef();
      c.olagan_disi.olagan_disi = ($urandom_range(0, 39) == 0);
      c.olagan_disi.mcause = 5'($urandom);
      tsg = {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)};
      osg = {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)};
      tsa = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      osa = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      step(c, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, tsg, tsa, osg, osa, h);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
